// File: rtl/parity_pkg.sv
// Shared types and constants for the streaming parity frame engine.
package parity_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_e;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;
  localparam logic GEN  = 1'b0;
  localparam logic CHK  = 1'b1;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_CNT_W  = 8;

endpackage

// File: rtl/parity_sat_counter.sv
// Saturating up-counter; clear wins over increment.
module parity_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/parity_frame_engine.sv
// Streaming parity generator/checker with running frame parity and
// a single-entry registered output stage.
module parity_frame_engine
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              odd_mode,
  input  logic              chk_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_word_par,
  output logic              out_frame_par,
  output logic              out_err,
  output logic              out_frame_err,
  output logic              out_last,
  output logic [CNT_W-1:0]  err_count,
  input  logic              err_clr
);

  state_e r_state;
  state_e w_state_next;

  logic r_acc, r_sticky, r_odd, r_chk;
  logic r_out_valid, r_word_par, r_frame_par, r_err, r_frame_err, r_last;

  logic w_accept, w_idle, w_odd, w_chk, w_xor;
  logic w_word_par, w_acc_next, w_frame_par, w_err, w_frame_err;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_idle   = (r_state == IDLE);

  // Mode bits come live from the ports on a frame's first word, held afterwards.
  assign w_odd       = w_idle ? odd_mode : r_odd;
  assign w_chk       = w_idle ? chk_mode : r_chk;
  assign w_xor       = ^in_data;
  assign w_word_par  = w_xor ^ (w_odd == ODD);
  assign w_acc_next  = (w_idle ? 1'b0 : r_acc) ^ w_xor;
  assign w_frame_par = w_acc_next ^ (w_odd == ODD);
  assign w_err       = (w_chk == CHK) && (w_word_par != in_par);
  assign w_frame_err = (w_idle ? 1'b0 : r_sticky) || w_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_accept) w_state_next = in_last ? IDLE : IN_FRAME;
  end

  // Frame accumulator, sticky error and captured mode bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= 1'b0;
      r_sticky <= 1'b0;
      r_odd    <= EVEN;
      r_chk    <= GEN;
    end else if (w_accept) begin
      r_acc    <= w_acc_next;
      r_sticky <= w_frame_err;
      if (w_idle) begin
        r_odd <= odd_mode;
        r_chk <= chk_mode;
      end
    end
  end

  // Output register: loads on accept, drains on out_ready, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_word_par  <= 1'b0;
      r_frame_par <= 1'b0;
      r_err       <= 1'b0;
      r_frame_err <= 1'b0;
      r_last      <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_word_par  <= w_word_par;
      r_frame_par <= w_frame_par;
      r_err       <= w_err;
      r_frame_err <= w_frame_err;
      r_last      <= in_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_word_par  = r_word_par;
  assign out_frame_par = r_frame_par;
  assign out_err       = r_err;
  assign out_frame_err = r_frame_err;
  assign out_last      = r_last;

  parity_sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (err_clr),
    .i_inc   (w_accept && w_err),
    .o_count (err_count)
  );

endmodule

// File: tb/tb_parity_frame_engine.sv
// Directed bench with a reference model and result scoreboard; a second
// instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_parity_frame_engine;

  typedef struct packed {
    logic wp;
    logic fp;
    logic err;
    logic ferr;
    logic last;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic odd_mode, chk_mode, in_valid, in_par, in_last, out_ready, err_clr;
  logic [7:0] in_data;
  logic in_ready, out_valid, out_word_par, out_frame_par, out_err, out_frame_err, out_last;
  logic [7:0] err_count;
  logic in_ready2, out_valid2, owp2, ofp2, oerr2, oferr2, olast2;
  logic [1:0] err_count2;

  int checks = 0;
  int errors = 0;

  res_t sb[$];
  logic m_infr, m_acc, m_sticky, m_odd, m_chk;
  int   m_cnt8, m_cnt2;

  always #5 clk = ~clk;

  parity_frame_engine #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .odd_mode(odd_mode), .chk_mode(chk_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_par(in_par),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_word_par(out_word_par), .out_frame_par(out_frame_par), .out_err(out_err),
    .out_frame_err(out_frame_err), .out_last(out_last), .err_count(err_count),
    .err_clr(err_clr));

  parity_frame_engine #(.DATA_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .odd_mode(odd_mode), .chk_mode(chk_mode),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_par(in_par),
    .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
    .out_word_par(owp2), .out_frame_par(ofp2), .out_err(oerr2),
    .out_frame_err(oferr2), .out_last(olast2), .err_count(err_count2),
    .err_clr(err_clr));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_infr = 1'b0; m_acc = 1'b0; m_sticky = 1'b0; m_odd = 1'b0; m_chk = 1'b0;
    m_cnt8 = 0; m_cnt2 = 0;
  endtask

  // One cycle: drive at negedge, check presented outputs, update model, clock.
  task automatic step(input logic v, input logic [7:0] d, input logic p,
                      input logic l, input logic rdy, input logic clr, output logic acc);
    logic xr, od, ck, wp, an, fp, er, fe, exp_rdy;
    res_t r;
    in_valid = v; in_data = d; in_par = p; in_last = l; out_ready = rdy; err_clr = clr;
    #1;
    chk("err_count", err_count, 8'(m_cnt8));
    chk("err_count_w2", {6'd0, err_count2}, 8'(m_cnt2));
    exp_rdy = (sb.size() == 0) || rdy;
    chk("in_ready", {7'd0, in_ready}, {7'd0, exp_rdy});
    chk("out_valid", {7'd0, out_valid}, {7'd0, sb.size() != 0});
    if (out_valid && sb.size() != 0) begin
      r = sb[0];
      chk("result", {3'd0, out_word_par, out_frame_par, out_err, out_frame_err, out_last},
          {3'd0, r});
      if (rdy) void'(sb.pop_front());
    end
    acc = v && exp_rdy;
    if (clr) m_cnt8 = 0;
    if (clr) m_cnt2 = 0;
    if (acc) begin
      xr = ^d;
      od = m_infr ? m_odd : odd_mode;
      ck = m_infr ? m_chk : chk_mode;
      wp = xr ^ od;
      an = (m_infr ? m_acc : 1'b0) ^ xr;
      fp = an ^ od;
      er = ck && (wp != p);
      fe = (m_infr ? m_sticky : 1'b0) | er;
      sb.push_back('{wp, fp, er, fe, l});
      if (!m_infr) begin m_odd = od; m_chk = ck; end
      m_acc = an; m_sticky = fe; m_infr = !l;
      if (er && !clr && m_cnt8 < 255) m_cnt8++;
      if (er && !clr && m_cnt2 < 3) m_cnt2++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_step();
    logic a;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, a);
  endtask

  task automatic word(input logic [7:0] d, input logic p, input logic l);
    logic a;
    step(1'b1, d, p, l, 1'b1, 1'b0, a);
    if (!a) chk("accept", 8'd0, 8'd1);
  endtask

  initial begin
    logic a;
    logic [7:0] bp_words [4];
    int idx, budget;
    rst = 1'b1; odd_mode = 0; chk_mode = 0; in_valid = 0; in_data = 0;
    in_par = 0; in_last = 0; out_ready = 1; err_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
    chk("rst_fields", {3'd0, out_word_par, out_frame_par, out_err, out_frame_err, out_last}, 8'd0);
    chk("rst_err_count", err_count, 8'd0);
    rst = 1'b0;
    @(negedge clk);

    // Even generate, single word
    word(8'hA5, 1'b0, 1'b1);
    #1;
    chk("a5_valid", {7'd0, out_valid}, 8'd1);
    chk("a5_bits", {5'd0, out_word_par, out_frame_par, out_last}, 8'b001);
    idle_step();

    // Odd single-word frames
    odd_mode = 1;
    word(8'h07, 1'b0, 1'b1);
    chk("odd07_wp", {7'd0, out_word_par}, 8'd0);
    word(8'h00, 1'b0, 1'b1);
    chk("odd00_wp", {7'd0, out_word_par}, 8'd1);
    idle_step();

    // Three-word even frame with odd_mode toggled mid-frame
    odd_mode = 0;
    word(8'h01, 1'b0, 1'b0);
    chk("f1_par", {6'd0, out_word_par, out_frame_par}, 8'b11);
    odd_mode = 1;
    word(8'h03, 1'b0, 1'b0);
    chk("f2_par", {6'd0, out_word_par, out_frame_par}, 8'b01);
    odd_mode = 0;
    word(8'h07, 1'b0, 1'b1);
    chk("f3_par", {6'd0, out_word_par, out_frame_par}, 8'b10);
    idle_step();

    // Check mode, even
    chk_mode = 1;
    word(8'hFF, 1'b0, 1'b0);
    chk("c1_err", {6'd0, out_err, out_frame_err}, 8'b00);
    word(8'h01, 1'b0, 1'b1);
    chk("c2_err", {6'd0, out_err, out_frame_err}, 8'b11);
    word(8'h03, 1'b0, 1'b1);
    chk("c3_ferr", {7'd0, out_frame_err}, 8'd0);
    chk("c_cnt", err_count, 8'd1);
    idle_step();

    // Backpressure: 3-cycle stall after the first result
    chk_mode = 0;
    bp_words[0] = 8'h11; bp_words[1] = 8'h12; bp_words[2] = 8'h37; bp_words[3] = 8'hF0;
    idx = 0; budget = 0;
    while (idx < 4 && budget < 40) begin
      step(1'b1, bp_words[idx], 1'b0, idx == 3, !(budget >= 1 && budget <= 3), 1'b0, a);
      if (a) idx++;
      budget++;
    end
    if (idx < 4) chk("bp_timeout", 8'(idx), 8'd4);
    idle_step();
    chk("bp_drained", 8'(sb.size()), 8'd0);

    // Saturation on the 2-bit instance
    chk_mode = 1;
    repeat (5) word(8'h01, 1'b0, 1'b1);
    idle_step();
    chk("sat_w2", {6'd0, err_count2}, 8'd3);
    chk("sat_w8", err_count, 8'd6);
    step(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, a);
    idle_step();
    chk("clr_prio_w8", err_count, 8'd0);
    chk("clr_prio_w2", {6'd0, err_count2}, 8'd0);

    // Reset mid-frame with a result pending
    chk_mode = 0;
    word(8'h01, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("mrst_valid", {7'd0, out_valid}, 8'd0);
    chk("mrst_ready", {7'd0, in_ready}, 8'd1);
    chk("mrst_fields", {3'd0, out_word_par, out_frame_par, out_err, out_frame_err, out_last}, 8'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    word(8'h01, 1'b0, 1'b1);
    chk("mrst_fp", {7'd0, out_frame_par}, 8'd1);
    idle_step();
    idle_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
